// File: rtl/dna_reader.sv
// Device-DNA port reader: divides clk to drive the DNA port, captures the 57-bit
// serial ID MSB first. Define DNA_READER_VERIFY_EN to require two matching reads.
module dna_reader #(
    parameter int CLK_DIV_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    output logic        dna_clk,
    output logic        dna_read,
    output logic        dna_shift,
    input  logic        dna_dout,
    output logic [56:0] id,
    output logic        valid
);

    localparam logic [CLK_DIV_LOG2-1:0] CNT_MAX = '1;
    localparam logic [CLK_DIV_LOG2-1:0] CNT_ONE = CLK_DIV_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CLK_DIV_LOG2-1:0] cnt_q, cnt_d;
    logic                    dna_clk_q, dna_clk_d;
    logic                    read_q, read_d;
    logic                    shift_q, shift_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [56:0]             sr_q, sr_d;
    logic [56:0]             id_q, id_d;
    logic                    valid_q, valid_d;
    logic                    tick_s;
    logic [56:0]             sr_full_s;
`ifdef DNA_READER_VERIFY_EN
    logic [56:0]             ref_q, ref_d;
    logic                    have_ref_q, have_ref_d;
`endif

    assign tick_s    = (cnt_q == CNT_MAX);
    assign sr_full_s = {sr_q[55:0], dna_dout};

    // Divider, capture FSM and output next-state logic; ticks fall with dna_clk.
    always_comb begin
        cnt_d     = cnt_q + CNT_ONE;
        dna_clk_d = cnt_d[CLK_DIV_LOG2-1];
        state_d   = state_q;
        read_d    = read_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        id_d      = id_q;
        valid_d   = valid_q;
`ifdef DNA_READER_VERIFY_EN
        ref_d      = ref_q;
        have_ref_d = have_ref_q;
`endif
        if (tick_s) begin
            case (state_q)
                IDLE: begin
                    state_d = LOAD;
                    read_d  = 1'b1;
                    shift_d = 1'b0;
                end
                LOAD: begin
                    state_d   = SHIFT;
                    read_d    = 1'b0;
                    shift_d   = 1'b1;
                    sr_d      = {56'd0, dna_dout};
                    bit_cnt_d = 6'd1;
                end
                SHIFT: begin
                    sr_d      = sr_full_s;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd56) begin
                        bit_cnt_d = 6'd0;
`ifdef DNA_READER_VERIFY_EN
                        // Each finished read is compared with the one before it.
                        if (have_ref_q && (sr_full_s == ref_q)) begin
                            state_d = DONE;
                            shift_d = 1'b0;
                            id_d    = sr_full_s;
                            valid_d = 1'b1;
                        end else begin
                            ref_d      = sr_full_s;
                            have_ref_d = 1'b1;
                            state_d    = LOAD;
                            read_d     = 1'b1;
                            shift_d    = 1'b0;
                        end
`else
                        state_d = DONE;
                        shift_d = 1'b0;
                        id_d    = sr_full_s;
                        valid_d = 1'b1;
`endif
                    end else begin
                        shift_d = 1'b1;
                    end
                end
                DONE: begin
                    read_d  = 1'b0;
                    shift_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    shift_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            dna_clk_q <= 1'b0;
            state_q   <= IDLE;
            read_q    <= 1'b0;
            shift_q   <= 1'b0;
            bit_cnt_q <= 6'd0;
            sr_q      <= 57'd0;
            id_q      <= 57'd0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dna_clk_q <= dna_clk_d;
            state_q   <= state_d;
            read_q    <= read_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
        end
    end

`ifdef DNA_READER_VERIFY_EN
    // Reference copy of the previous read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q      <= 57'd0;
            have_ref_q <= 1'b0;
        end else begin
            ref_q      <= ref_d;
            have_ref_q <= have_ref_d;
        end
    end
`endif

    assign dna_clk   = dna_clk_q;
    assign dna_read  = read_q;
    assign dna_shift = shift_q;
    assign id        = id_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_dna_reader.sv
// Directed bench for dna_reader with a behavioural DNA-port model.
module tb_dna_reader;

    localparam logic [56:0] DNA_NOM  = 57'h1_2345_6789_ABCD_EF;
    localparam logic [56:0] DNA_ONES = 57'h1FF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dna_clk, dna_read, dna_shift, dna_dout;
    logic [56:0] id;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    logic [56:0] model_val   = 57'd0;
    logic [56:0] model_sr    = 57'd0;
    int          n_read      = 0;
    int          n_shift     = 0;
    bit          corrupt_en  = 1'b0;
    int          corrupt_at  = 0;
    int          prot_err    = 0;
    logic        prev_clk    = 1'b0;
    logic        prev_read   = 1'b0;
    logic        prev_shift  = 1'b0;
    int          base_read, base_shift;

    dna_reader #(.CLK_DIV_LOG2(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .dna_clk   (dna_clk),
        .dna_read  (dna_read),
        .dna_shift (dna_shift),
        .dna_dout  (dna_dout),
        .id        (id),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    // DNA port model: READ loads, SHIFT shifts left; optional bit-0 corruption of one read.
    always @(posedge dna_clk) begin
        if (dna_read) begin
            model_sr <= (corrupt_en && n_read == corrupt_at) ? (model_val ^ 57'd1) : model_val;
            n_read   <= n_read + 1;
        end else if (dna_shift) begin
            model_sr <= {model_sr[55:0], 1'b0};
            n_shift  <= n_shift + 1;
        end
    end
    assign dna_dout = model_sr[56];

    // Protocol monitor sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (dna_read && dna_shift) prot_err <= prot_err + 1;
            if (((dna_read != prev_read) || (dna_shift != prev_shift)) && !(prev_clk && !dna_clk))
                prot_err <= prot_err + 1;
            if (!valid && id != 57'd0) prot_err <= prot_err + 1;
        end
        prev_clk   <= dna_clk;
        prev_read  <= dna_read;
        prev_shift <= dna_shift;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Hold reset 3 cycles, release on a falling edge; next posedge is edge 1.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        base_read  = n_read;
        base_shift = n_shift;
    endtask

    // Expect valid low after edge exp_edge-1 and high with the given id after exp_edge.
    task automatic expect_valid_at(input string tag, input int exp_edge, input logic [56:0] exp_id);
        repeat (exp_edge - 1) @(posedge clk);
        @(negedge clk);
        check({tag, "_pre"}, {63'd0, valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, valid}, 64'd1);
        check({tag, "_id"}, {7'd0, id}, {7'd0, exp_id});
    endtask

    initial begin
        @(negedge clk);
        check("reset_outputs", {6'd0, id, valid, dna_read, dna_shift, dna_clk}, 64'd0);

`ifndef DNA_READER_VERIFY_EN
        // Nominal capture.
        model_val = DNA_NOM;
        do_reset();
        expect_valid_at("nom", 1856, DNA_NOM);
        check("nom_read_periods", 64'(n_read - base_read), 64'd1);
        // 57 bits delivered: bit 56 from the READ load plus 56 SHIFT periods.
        check("nom_shift_periods", 64'(n_shift - base_shift), 64'd56);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("done_hold", {6'd0, id, valid, dna_read, dna_shift}, {6'd0, DNA_NOM, 1'b1, 1'b0, 1'b0});
        check("prot_nom", 64'(prot_err), 64'd0);

        // Reset mid-capture at edge 900 (tick 28 at edge 896: shifting).
        do_reset();
        repeat (900) @(posedge clk);
        #1;
        check("mid_shift_active", {63'd0, dna_shift}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_zero", {6'd0, id, valid, dna_read, dna_shift, dna_clk}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_valid_at("mid", 1856, DNA_NOM);

        // All-zero and all-one device values.
        model_val = 57'd0;
        do_reset();
        expect_valid_at("zeros", 1856, 57'd0);
        model_val = DNA_ONES;
        do_reset();
        expect_valid_at("ones", 1856, DNA_ONES);
        check("prot_all", 64'(prot_err), 64'd0);
`else
        // Double read, stable value.
        model_val = DNA_NOM;
        do_reset();
        expect_valid_at("ver", 3680, DNA_NOM);
        check("ver_read_periods", 64'(n_read - base_read), 64'd2);
        check("ver_shift_periods", 64'(n_shift - base_shift), 64'd112);

        // First read corrupted in bit 0: mismatch, then a clean re-read pair.
        corrupt_en = 1'b1;
        do_reset();
        corrupt_at = n_read;
        repeat (3680) @(posedge clk);
        @(negedge clk);
        check("ver_bad_no_valid", {63'd0, valid}, 64'd0);
        check("ver_bad_id_held", {7'd0, id}, 64'd0);
        expect_valid_at("ver_bad", 5504 - 3680, DNA_NOM);
        corrupt_en = 1'b0;
        check("prot_ver", 64'(prot_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
